// File: rtl/ddr3_app_sequencer.sv
// Single-outstanding request sequencer onto the MIG 7-series app interface, with a
// credit-protected read-return FIFO. Define DDR3_SEQ_WR_MASK_EN to forward byte write masks.
module ddr3_app_sequencer #(
    parameter int unsigned RD_FIFO_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH    = 28
) (
    input  logic                  i_ui_clk,
    input  logic                  i_ui_clk_sync_rst,
    input  logic                  i_init_calib_complete,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [ADDR_WIDTH-1:0] i_req_address,
    input  logic [127:0]          i_req_data,
    input  logic [15:0]           i_req_mask,
    output logic [ADDR_WIDTH-1:0] o_app_addr,
    output logic [2:0]            o_app_cmd,
    output logic                  o_app_en,
    input  logic                  i_app_rdy,
    output logic [127:0]          o_app_wdf_data,
    output logic [15:0]           o_app_wdf_mask,
    output logic                  o_app_wdf_wren,
    output logic                  o_app_wdf_end,
    input  logic                  i_app_wdf_rdy,
    input  logic [127:0]          i_app_rd_data,
    input  logic                  i_app_rd_data_valid,
    input  logic                  i_app_rd_data_end,
    output logic [127:0]          o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic                  o_rd_overflow
);

    localparam int unsigned PtrW = $clog2(RD_FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(RD_FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StWrIssue, StRdIssue} state_e;

    state_e                r_state, w_state_d;
    logic                  r_cmd_done, w_cmd_done_d;
    logic                  r_data_done, w_data_done_d;
    logic                  r_app_en, w_app_en_d;
    logic [2:0]            r_app_cmd, w_app_cmd_d;
    logic [ADDR_WIDTH-1:0] r_app_addr, w_app_addr_d;
    logic [127:0]          r_wdf_data, w_wdf_data_d;
    logic                  r_wdf_wren, w_wdf_wren_d;
    logic [CntW-1:0]       r_reserved;
    logic [CntW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [127:0]          r_mem [RD_FIFO_DEPTH];
    logic                  r_overflow;

    logic w_accept, w_cmd_hs, w_data_hs, w_cmd_fin, w_data_fin;
    logic w_pop, w_full, w_empty, w_push_ok;

    // State and registered app-side outputs
    always_ff @(posedge i_ui_clk) begin
        if (i_ui_clk_sync_rst) begin
            r_state     <= StIdle;
            r_cmd_done  <= 1'b0;
            r_data_done <= 1'b0;
            r_app_en    <= 1'b0;
            r_app_cmd   <= 3'b000;
            r_app_addr  <= '0;
            r_wdf_data  <= '0;
            r_wdf_wren  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cmd_done  <= w_cmd_done_d;
            r_data_done <= w_data_done_d;
            r_app_en    <= w_app_en_d;
            r_app_cmd   <= w_app_cmd_d;
            r_app_addr  <= w_app_addr_d;
            r_wdf_data  <= w_wdf_data_d;
            r_wdf_wren  <= w_wdf_wren_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_cmd_done_d  = 1'b0;
        w_data_done_d = 1'b0;
        w_app_en_d    = r_app_en & ~i_app_rdy;
        w_wdf_wren_d  = r_wdf_wren & ~i_app_wdf_rdy;
        w_app_cmd_d   = r_app_cmd;
        w_app_addr_d  = r_app_addr;
        w_wdf_data_d  = r_wdf_data;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d    = i_req_write ? StWrIssue : StRdIssue;
                    w_app_en_d   = 1'b1;
                    w_wdf_wren_d = i_req_write;
                    w_app_cmd_d  = i_req_write ? 3'b000 : 3'b001;
                    // One 128-bit beat per BL8 command: column bits [2:0] are always zero
                    w_app_addr_d = {i_req_address[ADDR_WIDTH-1:3], 3'b000};
                    if (i_req_write) w_wdf_data_d = i_req_data;
                end
            end
            StWrIssue: begin
                if (w_cmd_fin && w_data_fin) begin
                    w_state_d = StIdle;
                end else begin
                    w_cmd_done_d  = w_cmd_fin;
                    w_data_done_d = w_data_fin;
                end
            end
            StRdIssue: begin
                if (w_cmd_hs) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        o_req_ready = ~i_ui_clk_sync_rst & (r_state == StIdle) & i_init_calib_complete &
                      (r_reserved != DepthC);
        w_accept    = i_req_valid & o_req_ready;
        w_cmd_hs    = r_app_en & i_app_rdy;
        w_data_hs   = r_wdf_wren & i_app_wdf_rdy;
        w_cmd_fin   = r_cmd_done | w_cmd_hs;
        w_data_fin  = r_data_done | w_data_hs;
    end

    assign o_app_en       = r_app_en;
    assign o_app_cmd      = r_app_cmd;
    assign o_app_addr     = r_app_addr;
    assign o_app_wdf_data = r_wdf_data;
    assign o_app_wdf_wren = r_wdf_wren;
    assign o_app_wdf_end  = r_wdf_wren;

`ifdef DDR3_SEQ_WR_MASK_EN
    logic [15:0] r_wdf_mask;
    always_ff @(posedge i_ui_clk) begin
        if (i_ui_clk_sync_rst)           r_wdf_mask <= '0;
        else if (w_accept & i_req_write) r_wdf_mask <= i_req_mask;
    end
    assign o_app_wdf_mask = r_wdf_mask;
    logic w_unused;
    assign w_unused = i_app_rd_data_end;
`else
    assign o_app_wdf_mask = 16'h0000;
    logic w_unused;
    assign w_unused = i_app_rd_data_end ^ (^i_req_mask);
`endif

    // Read-return FIFO: the MIG read path has no back-pressure, so space is reserved at accept
    assign w_pop     = o_rd_valid & i_rd_ready;
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = ((r_wr_ptr - r_rd_ptr) == DepthC);
    assign w_push_ok = i_app_rd_data_valid & (~w_full | w_pop);

    always_ff @(posedge i_ui_clk) begin
        if (i_ui_clk_sync_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_reserved <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + CntW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + CntW'(1);
            if (i_app_rd_data_valid & ~w_push_ok) r_overflow <= 1'b1;
            case ({w_accept & ~i_req_write, w_pop})
                2'b10:   r_reserved <= r_reserved + CntW'(1);
                2'b01:   r_reserved <= r_reserved - CntW'(1);
                default: r_reserved <= r_reserved;
            endcase
        end
    end

    always_ff @(posedge i_ui_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[PtrW-1:0]] <= i_app_rd_data;
    end

    assign o_rd_valid    = ~w_empty;
    assign o_rd_data     = w_empty ? '0 : r_mem[r_rd_ptr[PtrW-1:0]];
    assign o_rd_overflow = r_overflow;

endmodule
